// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder: MemOp
//               (func3) encodings, FSM state type and the access-fault check.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RISC-V load/store func3 encodings
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Flags an illegal memop (including unsigned stores) or a misaligned lane.
  function automatic logic access_fault(input logic [2:0] memop,
                                        input logic       wen,
                                        input logic [1:0] lane);
    logic f;
    f = 1'b0;
    case (memop)
      MEMOP_B:  f = 1'b0;
      MEMOP_H:  f = lane[0];
      MEMOP_W:  f = (lane != 2'b00);
      MEMOP_BU: f = wen;
      MEMOP_HU: f = wen | lane[0];
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering. Produces byte enables and
//               the lane-replicated write word for stores, and the extracted,
//               sign/zero-extended result for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store path: data is replicated across lanes, byte enables pick the target lanes.
  always_comb begin
    o_be    = 4'b0000;
    o_wword = 32'h0;
    case (i_memop)
      MEMOP_B: begin
        o_be    = 4'b0001 << i_lane;
        o_wword = {4{i_wdata[7:0]}};
      end
      MEMOP_H: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
      end
      MEMOP_W: begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wword = 32'h0;
      end
    endcase
  end

  // Load path: select the addressed lane and extend to 32 bits.
  always_comb begin
    w_byte  = i_rword[{i_lane, 3'b000} +: 8];
    w_half  = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    o_rdata = 32'h0;
    case (i_memop)
      MEMOP_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
      MEMOP_H:  o_rdata = {{16{w_half[15]}}, w_half};
      MEMOP_W:  o_rdata = i_rword;
      MEMOP_BU: o_rdata = {24'h0, w_byte};
      MEMOP_HU: o_rdata = {16'h0, w_half};
      default:  o_rdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder. Accepts one load/store per valid/ready
//               handshake, inserts LATENCY wait states, performs the RISC-V
//               byte/half/word access on a word-organised RAM and returns the
//               result on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          c_AW    = $clog2(DEPTH);
  localparam logic [32:0] c_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  c_LAT   = 4'(LATENCY);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [2:0]  r_memop;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH];

  logic            w_accept;
  logic [31:0]     w_off;
  logic            w_oor;
  logic [c_AW-1:0] w_word;
  logic            w_err;
  logic            w_enter_resp;
  logic            w_commit;
  logic [3:0]      w_be;
  logic [31:0]     w_wword;
  logic [31:0]     w_rdata;

  assign req_ready = rst & (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Decode of the latched request; all inputs are registers so this is stable during WAIT.
  assign w_off  = r_addr - BASE;
  assign w_oor  = ({1'b0, w_off} >= c_LIMIT);
  assign w_word = w_off[c_AW+1:2];
  assign w_err  = w_oor | access_fault(r_memop, r_wen, w_off[1:0]);

  // The accepting edge always lands in WAIT, so the latched request is in place
  // before the RAM access; the access edge is the one leaving WAIT with count 0.
  assign w_enter_resp = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_commit     = w_enter_resp & r_wen & ~w_err;

  dmem_lane_align u_align (
    .i_memop (r_memop),
    .i_lane  (w_off[1:0]),
    .i_wdata (r_wdata),
    .i_rword (r_mem[w_word]),
    .o_be    (w_be),
    .o_wword (w_wword),
    .o_rdata (w_rdata)
  );

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0)     w_next = ST_RESP;
      ST_RESP: if (resp_ready)        w_next = ST_IDLE;
      default:                        w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_cnt <= 4'd0;
    else if (w_accept)                            r_cnt <= c_LAT;
    else if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Request capture; only an accepted handshake updates these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'h0;
      r_wen   <= 1'b0;
      r_memop <= 3'b000;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wen   <= req_wen;
      r_memop <= req_memop;
      r_wdata <= req_wdata;
    end
  end

  // Response registers: loaded on RESP entry, held until the handshake completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      resp_valid <= 1'b1;
      resp_err   <= w_err;
      resp_rdata <= (w_err || r_wen) ? 32'h0 : w_rdata;
    end else if (r_state == ST_RESP && resp_ready) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end
  end

  // RAM byte-lane write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder with a queue of
//               expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .BASE    (32'h8000_0000),
    .DEPTH   (4096),
    .LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_memop  (req_memop),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc = 0;
  int last_lat = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Drive one request, wait (bounded) for acceptance and queue its expected response.
  task automatic send(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic eerr, input logic [31:0] erd,
                      input string nm);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_memop = op;
    req_addr  = addr;
    req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready);
    end
    e.err = eerr; e.rdata = erd; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5_A5A5;
  endtask

  // Wait (bounded) for a response, compare against the queue head, then handshake.
  task automatic recv();
    exp_t e;
    int   k;
    @(negedge clk);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    last_lat = cyc - acc_cyc;
    e = sb.pop_front();
    n_tests++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: resp_valid=%b required 1", e.name, resp_valid);
    end else if (resp_err !== e.err || resp_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL %s: rdata=%h err=%b, required rdata=%h err=%b",
               e.name, resp_rdata, resp_err, e.rdata, e.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic eerr, input logic [31:0] erd,
                      input string nm);
    send(wen, op, addr, wdata, eerr, erd, nm);
    recv();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_low: req_ready=%b required 0", req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_latency();
    xact(1'b1, OP_W, 32'h8000_0004, 32'h1234_5678, 1'b0, 32'h0, "sw_word");
    n_tests++;
    if (last_lat != 3) begin
      n_fail++; $display("FAIL store_latency: %0d cycles, required 3", last_lat);
    end
    xact(1'b0, OP_W, 32'h8000_0004, 32'h0, 1'b0, 32'h1234_5678, "lw_word");
    n_tests++;
    if (last_lat != 3) begin
      n_fail++; $display("FAIL load_latency: %0d cycles, required 3", last_lat);
    end
  endtask

  task automatic test_subword();
    xact(1'b1, OP_W,  32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0,         "sw_zero");
    xact(1'b1, OP_B,  32'h8000_0001, 32'h1234_56AB, 1'b0, 32'h0,         "sb_lane1");
    xact(1'b0, OP_W,  32'h8000_0000, 32'h0,         1'b0, 32'h0000_AB00, "lw_after_sb");
    xact(1'b0, OP_B,  32'h8000_0001, 32'h0,         1'b0, 32'hFFFF_FFAB, "lb_sext");
    xact(1'b0, OP_BU, 32'h8000_0001, 32'h0,         1'b0, 32'h0000_00AB, "lbu_zext");
    xact(1'b1, OP_H,  32'h8000_0002, 32'hCAFE_8001, 1'b0, 32'h0,         "sh_upper");
    xact(1'b0, OP_W,  32'h8000_0000, 32'h0,         1'b0, 32'h8001_AB00, "lw_after_sh");
    xact(1'b0, OP_H,  32'h8000_0002, 32'h0,         1'b0, 32'hFFFF_8001, "lh_sext");
    xact(1'b0, OP_HU, 32'h8000_0002, 32'h0,         1'b0, 32'h0000_8001, "lhu_zext");
    xact(1'b0, OP_H,  32'h8000_0000, 32'h0,         1'b0, 32'hFFFF_AB00, "lh_lower");
    xact(1'b0, OP_B,  32'h8000_0003, 32'h0,         1'b0, 32'hFFFF_FF80, "lb_lane3");
    xact(1'b0, OP_B,  32'h8000_0000, 32'h0,         1'b0, 32'h0000_0000, "lb_lane0");
  endtask

  task automatic test_errors();
    xact(1'b0, OP_H,   32'h8000_0003, 32'h0,         1'b1, 32'h0, "lh_misaligned");
    xact(1'b1, OP_W,   32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0, "sw_misaligned");
    xact(1'b0, OP_W,   32'h8000_0000, 32'h0,         1'b0, 32'h8001_AB00, "lw_unchanged");
    xact(1'b0, OP_W,   32'h8000_4000, 32'h0,         1'b1, 32'h0, "lw_out_of_range");
    xact(1'b0, OP_W,   32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0, "lw_below_base");
    xact(1'b0, 3'b011, 32'h8000_0000, 32'h0,         1'b1, 32'h0, "illegal_op");
    xact(1'b1, OP_BU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, "unsigned_store");
    xact(1'b0, OP_W,   32'h8000_0000, 32'h0,         1'b0, 32'h8001_AB00, "lw_still_unchanged");
    xact(1'b1, OP_W,   32'h8000_3FFC, 32'h0BAD_F00D, 1'b0, 32'h0, "sw_last_word");
    xact(1'b0, OP_W,   32'h8000_3FFC, 32'h0,         1'b0, 32'h0BAD_F00D, "lw_last_word");
  endtask

  task automatic test_stall();
    exp_t e;
    int   k;
    int   hs;
    resp_ready = 1'b0;
    send(1'b0, OP_W, 32'h8000_0004, 32'h0, 1'b0, 32'h1234_5678, "lw_stall");
    @(negedge clk);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
      n_fail++;
      $display("FAIL %s: valid=%b rdata=%h err=%b, required 1 %h %b",
               e.name, resp_valid, resp_rdata, resp_err, e.rdata, e.err);
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b rdata=%h ready=%b, required 1 %h 0",
                 resp_valid, resp_rdata, req_ready, e.rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
    send(1'b0, OP_W, 32'h8000_0004, 32'h0, 1'b0, 32'h1234_5678, "lw_after_stall");
    n_tests++;
    if (acc_cyc != hs + 1) begin
      n_fail++; $display("FAIL next_accept: cycle %0d, required %0d", acc_cyc, hs + 1);
    end
    recv();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    xact(1'b1, OP_W, 32'h8000_0008, 32'h1122_3344, 1'b0, 32'h0, "sw_pre");
    send(1'b1, OP_W, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0, "sw_abort");
    e = sb.pop_back();   // this store's response is dropped by the reset
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               e.name, req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (5) @(posedge clk);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_valid: resp_valid=%b required 0", resp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, OP_W, 32'h8000_0008, 32'h0, 1'b0, 32'h1122_3344, "lw_after_abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
